// File: rtl/cp0_epc_stack.sv
// Exception-PC stack for CP0: captures the return PC of each nested exception,
// pops on ERET, and exposes the top-of-stack slot as the software-visible EPC.
module cp0_epc_stack #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4,
  parameter int BD_OFFSET = 4,
  parameter int EPC_ADDR  = 14,
  parameter int LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exception,
  input  logic [XLEN-1:0]  exc_pc,
  input  logic             exc_bd,
  input  logic             eret,
  input  logic             mtc0_we,
  input  logic [5:0]       cp0_addr,
  input  logic [XLEN-1:0]  mtc0_data,
  input  logic             flag_clr,
  output logic [XLEN-1:0]  epc_out,
  output logic [LVL_W-1:0] level,
  output logic             exl,
  output logic             overflow,
  output logic             underflow
);

  logic [XLEN-1:0]  entry_q [DEPTH];
  logic [XLEN-1:0]  entry_d [DEPTH];
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             unf_q;
  logic             unf_d;

  logic [LVL_W-1:0] show_idx_s;
  logic [XLEN-1:0]  show_val_s;
  logic [XLEN-1:0]  cap_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             mtc0_hit_s;
  logic             mtc0_wr_s;

  assign full_s  = (level_q == LVL_W'(DEPTH));
  assign empty_s = (level_q == {LVL_W{1'b0}});

  // Visible slot: entry[0] when empty, else the most recently pushed entry.
  always_comb begin
    show_idx_s = empty_s ? {LVL_W{1'b0}} : (level_q - LVL_W'(1));
    show_val_s = entry_q[0];
    for (int i = 0; i < DEPTH; i++) begin
      show_val_s = (show_idx_s == LVL_W'(i)) ? entry_q[i] : show_val_s;
    end
  end

  // Strobe decode with rst > exception > eret > mtc0 priority.
  always_comb begin
    cap_s      = exc_bd ? (exc_pc - XLEN'(BD_OFFSET)) : exc_pc;
    mtc0_hit_s = mtc0_we && (cp0_addr == 6'(EPC_ADDR));
    push_s     = exception && !full_s;
    pop_s      = !exception && eret && !empty_s;
    mtc0_wr_s  = !exception && !eret && mtc0_hit_s;
  end

  // Next-state: sticky flags clear on flag_clr unless set in the same cycle.
  always_comb begin
    level_d = level_q;
    ovf_d   = ovf_q & ~flag_clr;
    unf_d   = unf_q & ~flag_clr;
    if (exception) begin
      if (!full_s) begin
        level_d = level_q + LVL_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (eret) begin
      if (!empty_s) begin
        level_d = level_q - LVL_W'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else begin
      level_d = level_q;
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (push_s && (level_q == LVL_W'(i))) begin
        entry_d[i] = cap_s;
      end else if (mtc0_wr_s && (show_idx_s == LVL_W'(i))) begin
        entry_d[i] = mtc0_data;
      end else begin
        entry_d[i] = entry_q[i];
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= {XLEN{1'b0}};
      end
      level_q <= {LVL_W{1'b0}};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign epc_out   = show_val_s;
  assign level     = level_q;
  assign exl       = ~empty_s;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_cp0_epc_stack.sv
// Directed bench for cp0_epc_stack: the driver queues hand-computed expectations,
// a monitor compares them against the DUT one cycle after each applied vector.
module tb_cp0_epc_stack;

  logic        clk;
  logic        rst;
  logic        exception;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        eret;
  logic        mtc0_we;
  logic [5:0]  cp0_addr;
  logic [31:0] mtc0_data;
  logic        flag_clr;
  logic [31:0] epc_out;
  logic [2:0]  level;
  logic        exl;
  logic        overflow;
  logic        underflow;

  typedef struct {
    string       name;
    logic [31:0] epc;
    logic [2:0]  lvl;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  cp0_epc_stack dut (
    .clk       (clk),
    .rst       (rst),
    .exception (exception),
    .exc_pc    (exc_pc),
    .exc_bd    (exc_bd),
    .eret      (eret),
    .mtc0_we   (mtc0_we),
    .cp0_addr  (cp0_addr),
    .mtc0_data (mtc0_data),
    .flag_clr  (flag_clr),
    .epc_out   (epc_out),
    .level     (level),
    .exl       (exl),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input string fld, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got=%h want=%h", name, fld, act, exp);
    end
  endtask

  // Monitor: one expectation per applied vector, checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.name, "epc",   epc_out,          e.epc);
        chk(e.name, "level", {29'd0, level},   {29'd0, e.lvl});
        chk(e.name, "exl",   {31'd0, exl},     {31'd0, (e.lvl != 3'd0)});
        chk(e.name, "ovf",   {31'd0, overflow},  {31'd0, e.ovf});
        chk(e.name, "unf",   {31'd0, underflow}, {31'd0, e.unf});
      end
    end
  end

  task automatic step(input string name,
                      input logic r, input logic ex, input logic [31:0] pc, input logic bd,
                      input logic er, input logic we, input logic [5:0] addr,
                      input logic [31:0] data, input logic clr,
                      input logic [31:0] x_epc, input logic [2:0] x_lvl,
                      input logic x_ovf, input logic x_unf);
    exp_t e;
    @(negedge clk);
    rst = r; exception = ex; exc_pc = pc; exc_bd = bd; eret = er;
    mtc0_we = we; cp0_addr = addr; mtc0_data = data; flag_clr = clr;
    e.name = name; e.epc = x_epc; e.lvl = x_lvl; e.ovf = x_ovf; e.unf = x_unf;
    sb_q.push_back(e);
  endtask

  task automatic push(input string n, input logic [31:0] pc, input logic bd,
                      input logic [31:0] x_epc, input logic [2:0] x_lvl, input logic x_ovf);
    step(n, 1'b0, 1'b1, pc, bd, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, x_epc, x_lvl, x_ovf, 1'b0);
  endtask

  task automatic pop(input string n, input logic [31:0] x_epc, input logic [2:0] x_lvl,
                     input logic x_ovf, input logic x_unf);
    step(n, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0, 1'b0, x_epc, x_lvl, x_ovf, x_unf);
  endtask

  task automatic reset_dut(input string n);
    step(n, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int wait_cyc;
    rst = 1'b1; exception = 1'b0; exc_pc = 32'h0; exc_bd = 1'b0; eret = 1'b0;
    mtc0_we = 1'b0; cp0_addr = 6'd0; mtc0_data = 32'h0; flag_clr = 1'b0;

    reset_dut("reset");
    push("exc_plain", 32'h8000_1000, 1'b0, 32'h8000_1000, 3'd1, 1'b0);
    push("exc_bd",    32'h8000_2004, 1'b1, 32'h8000_2000, 3'd2, 1'b0);
    reset_dut("reset2");
    push("exc_bd_wrap", 32'h0000_0002, 1'b1, 32'hFFFF_FFFE, 3'd1, 1'b0);
    reset_dut("reset3");

    push("fill1", 32'h100, 1'b0, 32'h100, 3'd1, 1'b0);
    push("fill2", 32'h200, 1'b0, 32'h200, 3'd2, 1'b0);
    push("fill3", 32'h300, 1'b0, 32'h300, 3'd3, 1'b0);
    push("fill4", 32'h400, 1'b0, 32'h400, 3'd4, 1'b0);
    push("overflow", 32'h500, 1'b0, 32'h400, 3'd4, 1'b1);
    pop("eret1", 32'h300, 3'd3, 1'b1, 1'b0);
    pop("eret2", 32'h200, 3'd2, 1'b1, 1'b0);
    pop("eret3", 32'h100, 3'd1, 1'b1, 1'b0);
    pop("eret4_empty", 32'h100, 3'd0, 1'b1, 1'b0);
    pop("underflow", 32'h100, 3'd0, 1'b1, 1'b1);
    step("flag_clr", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1,
         32'h100, 3'd0, 1'b0, 1'b0);

    push("mt_push1", 32'hA00, 1'b0, 32'hA00, 3'd1, 1'b0);
    push("mt_push2", 32'hB00, 1'b0, 32'hB00, 3'd2, 1'b0);
    step("mtc0_hit", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 6'd14, 32'hBFC0_0380, 1'b0,
         32'hBFC0_0380, 3'd2, 1'b0, 1'b0);
    pop("mt_eret", 32'hA00, 3'd1, 1'b0, 1'b0);
    step("mtc0_miss", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 6'd12, 32'hDEAD_BEEF, 1'b0,
         32'hA00, 3'd1, 1'b0, 1'b0);

    step("exc_eret_mtc0", 1'b0, 1'b1, 32'h900, 1'b0, 1'b1, 1'b1, 6'd14, 32'h555, 1'b0,
         32'h900, 3'd2, 1'b0, 1'b0);
    step("eret_mtc0", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 6'd14, 32'h123, 1'b0,
         32'hA00, 3'd1, 1'b0, 1'b0);
    pop("to_empty", 32'hA00, 3'd0, 1'b0, 1'b0);
    step("mtc0_lvl0", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 6'd14, 32'h777, 1'b0,
         32'h777, 3'd0, 1'b0, 1'b0);

    push("r_push1", 32'h10, 1'b0, 32'h10, 3'd1, 1'b0);
    push("r_push2", 32'h20, 1'b0, 32'h20, 3'd2, 1'b0);
    push("r_push3", 32'h30, 1'b0, 32'h30, 3'd3, 1'b0);
    step("rst_with_exc", 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0,
         32'h0, 3'd0, 1'b0, 1'b0);

    push("o_push1", 32'h1000, 1'b0, 32'h1000, 3'd1, 1'b0);
    push("o_push2", 32'h2000, 1'b0, 32'h2000, 3'd2, 1'b0);
    push("o_push3", 32'h3000, 1'b0, 32'h3000, 3'd3, 1'b0);
    push("o_push4", 32'h4000, 1'b0, 32'h4000, 3'd4, 1'b0);
    step("ovf_vs_clr", 1'b0, 1'b1, 32'h5000, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1,
         32'h4000, 3'd4, 1'b1, 1'b0);
    step("clr_ovf", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1,
         32'h4000, 3'd4, 1'b0, 1'b0);
    pop("u_eret1", 32'h3000, 3'd3, 1'b0, 1'b0);
    pop("u_eret2", 32'h2000, 3'd2, 1'b0, 1'b0);
    pop("u_eret3", 32'h1000, 3'd1, 1'b0, 1'b0);
    pop("u_eret4", 32'h1000, 3'd0, 1'b0, 1'b0);
    step("unf_vs_clr", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0, 1'b1,
         32'h1000, 3'd0, 1'b0, 1'b1);

    @(negedge clk);
    rst = 1'b0; exception = 1'b0; eret = 1'b0; mtc0_we = 1'b0; flag_clr = 1'b0;
    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_epc_stack.md
Name: cp0_epc_stack

Overview:
- Parametrised exception-PC unit for the CP0 block; generalises the single EPC register into a DEPTH-entry stack so nested exceptions keep their return addresses.
- Captures the faulting PC on exception, with delay-slot adjustment. Pops on ERET. Supports software MTC0 writes to the visible EPC.
- Sits beside the other CP0 registers and is fed from the MEM/WB stage exception signals.

Parameters:
XLEN, 32, data/PC width
DEPTH, 4, number of stacked EPC entries (>=1); DEPTH=1 gives classic single-EPC behaviour
BD_OFFSET, 4, subtracted from the PC when the excepting instruction is in a delay slot
EPC_ADDR, 14, CP0 register address decoded for MTC0 writes
LVL_W, $clog2(DEPTH+1), width of the level counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
exception  in  1  exception committed this cycle
exc_pc  in  XLEN  PC of the excepting instruction
exc_bd  in  1  excepting instruction is in a branch delay slot
eret  in  1  ERET committed this cycle
mtc0_we  in  1  MTC0 write strobe
cp0_addr  in  6  CP0 register address for MTC0
mtc0_data  in  XLEN  MTC0 write data
flag_clr  in  1  clears the sticky overflow/underflow flags
epc_out  out  XLEN  visible EPC; also the ERET target
level  out  LVL_W  number of valid stacked entries
exl  out  1  level != 0
overflow  out  1  sticky: exception arrived while the stack was full
underflow  out  1  sticky: ERET arrived while the stack was empty

Behaviour:
- Reset (rst=1 at a clock edge): all entries = 0, level = 0, overflow = 0, underflow = 0. Therefore epc_out = 0 and exl = 0. Reset overrides every other input in that cycle.
- Stored value: cap = exc_bd ? exc_pc - BD_OFFSET : exc_pc, computed modulo 2^XLEN (wraps, e.g. 0x2 - 4 = 0xFFFFFFFE).
- epc_out is combinational from state: level==0 gives entry[0]; otherwise entry[level-1]. exl = (level != 0).
- All updates take one cycle; new values are visible on the outputs the cycle after the strobe.
- Exception:
  - level < DEPTH: entry[level] <= cap; level <= level+1.
  - level == DEPTH: no entry or level change; overflow <= 1. With DEPTH=1 this reproduces EXL-suppressed EPC update.
- ERET:
  - level > 0: level <= level-1; entries are unchanged.
  - level == 0: no change; underflow <= 1.
- MTC0 (mtc0_we && cp0_addr==EPC_ADDR): the slot currently shown on epc_out is written with mtc0_data. That slot is entry[0] when level==0, else entry[level-1]. level is unchanged.
- Priority within one cycle: rst > exception > eret > mtc0. The lower-priority strobes are ignored entirely, with no flag side effects.
  - exception+eret: push only.
  - exception+mtc0: push only; the MTC0 is lost.
  - eret+mtc0: pop only.
- flag_clr clears both sticky flags. If a flag-setting event occurs in the same cycle, the set wins.
- Entries above level hold stale data and are never shown.

Test Plan:
- Reset, then exception exc_pc=0x80001000, exc_bd=0 -> next cycle epc_out=0x80001000, level=1, exl=1.
- Exception exc_pc=0x80002004, exc_bd=1 -> epc_out=0x80002000. Then exc_pc=0x2, exc_bd=1 on a fresh stack -> epc_out=0xFFFFFFFE (wrap).
- DEPTH=4: push 0x100, 0x200, 0x300, 0x400; push 0x500 -> level=4, epc_out=0x400, overflow=1. Then 4 ERETs -> epc_out 0x300, 0x200, 0x100, then level=0 with epc_out=0x100 (entry[0]). A 5th ERET -> underflow=1, level=0.
- level=2, MTC0 addr=14 data=0xBFC00380 -> epc_out=0xBFC00380. ERET -> the level-1 entry is unchanged. MTC0 with addr=12 -> no change.
- Same-cycle exception(0x900)+eret+mtc0 at level=1 -> level=2, epc_out=0x900. Next cycle eret+mtc0(0x123) -> level=1, prior entry shown, 0x123 not written.
- rst asserted mid-operation with exception high at level=3 -> next cycle level=0, epc_out=0, flags 0. flag_clr together with overflow-causing exception -> overflow stays 1.
